// File: rtl/vector_minmax_sequencer.sv
// Vector min/max sequencer: walks one instruction across its LMUL register group,
// feeding the registered 2-cycle min/max unit one register per cycle and
// retiring results to the vector register file as they emerge.

package vector_minmax_pkg;

  // Decoded min/max control carried to the datapath for the whole group.
  typedef struct packed {
    logic       is_signed;  // 1: signed compare, 0: unsigned compare
    logic       is_max;     // 1: max, 0: min
    logic [1:0] sew;        // element width: 0->8, 1->16, 2->32, 3->64 bits
  } execution_vector_t;

endpackage

// Sequencer top.
// Occupancy is L+3 cycles per instruction (L+1 after handshake before the last
// write-back, then one cycle back in IDLE); misaligned requests take 2 cycles.
// req_ready is only high in IDLE; a request seen while busy must be held.
module vector_minmax_sequencer
  import vector_minmax_pkg::*;
#(
  parameter int VLEN  = 128,
  parameter int RF_AW = 5
) (
  input  logic              clock,
  input  logic              reset_n,

  input  logic              req_valid,
  output logic              req_ready,
  input  execution_vector_t req_exec,
  input  logic [1:0]        req_lmul,
  input  logic [RF_AW-1:0]  req_vs2,
  input  logic [RF_AW-1:0]  req_vs1,
  input  logic [RF_AW-1:0]  req_vd,

  output logic [RF_AW-1:0]  rf_ra_a,
  output logic [RF_AW-1:0]  rf_ra_b,
  input  logic [VLEN-1:0]   rf_rd_a,
  input  logic [VLEN-1:0]   rf_rd_b,

  output execution_vector_t unit_exec,
  output logic [VLEN-1:0]   unit_vs2,
  output logic [VLEN-1:0]   unit_vs1,
  input  logic [VLEN-1:0]   unit_vd,

  output logic              wb_valid,
  output logic [RF_AW-1:0]  wb_addr,
  output logic [VLEN-1:0]   wb_data,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nxt;

  // Captured instruction; sampled only on the handshake cycle.
  execution_vector_t exec_q;
  logic [2:0]        last_idx_q;   // L-1 of the accepted group
  logic [RF_AW-1:0]  vs2_base;
  logic [RF_AW-1:0]  vs1_base;
  logic [RF_AW-1:0]  vd_base;
  logic [2:0]        idx;          // element currently being issued

  // Two-deep tracker mirroring the min/max unit pipeline. Stage 0 is the
  // element the unit is computing, stage 1 the element presented on unit_vd.
  logic              trk0_vld;
  logic [RF_AW-1:0]  trk0_addr;
  logic              trk1_vld;
  logic [RF_AW-1:0]  trk1_addr;

  logic              accept;
  logic [2:0]        req_last_idx;
  logic [RF_AW-1:0]  req_mask;
  logic              req_misaligned;
  logic              issuing;
  logic              issue_last;
  logic [RF_AW-1:0]  idx_ext;

  assign accept    = req_valid && req_ready;
  assign issuing   = (state == ST_ISSUE);
  assign idx_ext   = RF_AW'(idx);
  assign issue_last = issuing && (idx == last_idx_q);

  // Decode the group length code into the index of the last register.
  always_comb begin
    req_last_idx = 3'd0;
    case (req_lmul)
      2'd0:    req_last_idx = 3'd0;
      2'd1:    req_last_idx = 3'd1;
      2'd2:    req_last_idx = 3'd3;
      default: req_last_idx = 3'd7;
    endcase
  end

  // A base is aligned when its low log2(L) bits are zero; OR-ing the three
  // bases first flags the request if any one of them has a stray low bit.
  assign req_mask       = RF_AW'(req_last_idx);
  assign req_misaligned = |((req_vs2 | req_vs1 | req_vd) & req_mask);

  // Next-state selection for the instruction sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = req_misaligned ? ST_ERR : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (issue_last) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Nothing left behind the final element, and the final element is
        // being written back this cycle.
        if (!trk0_vld && trk1_vld) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture the instruction on the handshake and step the element index.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exec_q     <= '0;
      last_idx_q <= 3'd0;
      vs2_base   <= '0;
      vs1_base   <= '0;
      vd_base    <= '0;
      idx        <= 3'd0;
    end else if (accept) begin
      exec_q     <= req_exec;
      last_idx_q <= req_last_idx;
      vs2_base   <= req_vs2;
      vs1_base   <= req_vs1;
      vd_base    <= req_vd;
      idx        <= 3'd0;
    end else if (issuing) begin
      idx        <= idx + 3'd1;
    end
  end

  // Track in-flight destinations; bubbles are pushed whenever nothing issues.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      trk0_vld  <= 1'b0;
      trk0_addr <= '0;
      trk1_vld  <= 1'b0;
      trk1_addr <= '0;
    end else begin
      trk0_vld  <= issuing;
      trk0_addr <= issuing ? (vd_base + idx_ext) : '0;
      trk1_vld  <= trk0_vld;
      trk1_addr <= trk0_addr;
    end
  end

  // Read side: address the current element and forward its operands. Both
  // are forced to zero outside ISSUE so the unit sees clean idle inputs.
  always_comb begin
    rf_ra_a  = '0;
    rf_ra_b  = '0;
    unit_vs2 = '0;
    unit_vs1 = '0;
    if (issuing) begin
      rf_ra_a  = vs2_base + idx_ext;
      rf_ra_b  = vs1_base + idx_ext;
      unit_vs2 = rf_rd_a;
      unit_vs1 = rf_rd_b;
    end
  end

  assign unit_exec = exec_q;
  assign req_ready = (state == ST_IDLE);
  assign err       = (state == ST_ERR);

  // Write side: the tracker's output stage lines up with unit_vd.
  assign wb_valid = trk1_vld;
  assign wb_addr  = trk1_addr;
  assign wb_data  = unit_vd;

  // The last write-back is the one with nothing valid behind it while draining.
  assign done = trk1_vld && !trk0_vld && (state == ST_DRAIN);

  // Write-backs only ever occur while an instruction owns the datapath.
  a_wb_owned: assert property (@(posedge clock) disable iff (!reset_n)
    wb_valid |-> (state == ST_ISSUE || state == ST_DRAIN));

  // A rejected request never reaches the datapath.
  a_err_quiet: assert property (@(posedge clock) disable iff (!reset_n)
    err |-> (!wb_valid && !trk0_vld));

endmodule
